// File: rtl/baud_tick_gen.sv
// Programmable UART bit-timing generator: mid-bit, bit-end and oversample strobes
// plus frame bit index, all derived from one runtime-loadable divisor.
module baud_tick_gen #(
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 5208,
   parameter int OS_LOG2     = 4,
   parameter int FRAME_BITS  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bps_start,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_load,
   output logic             tick_mid,
   output logic             tick_end,
   output logic             tick_os,
   output logic [3:0]       bit_idx,
   output logic             frame_done,
   output logic             div_err,
   output logic [CNT_W-1:0] div_cur
);

   localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
   localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   logic             pend_v_q, pend_v_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
   logic [3:0]       bit_idx_q, bit_idx_d;
   logic             tick_mid_q, tick_mid_d;
   logic             tick_end_q, tick_end_d;
   logic             tick_os_q, tick_os_d;
   logic             frame_done_q, frame_done_d;
   logic             div_err_q, div_err_d;

   logic [CNT_W-1:0] half;
   logic [CNT_W-1:0] os_shift;
   logic [CNT_W-1:0] os_div;
   logic             cnt_last;
   logic             os_last;
   logic             load_ok;

   assign half     = div_q >> 1;
   assign os_shift = div_q >> OS_LOG2;
   assign os_div   = (os_shift == '0) ? CNT_W'(1) : os_shift;
   assign cnt_last = (cnt_q == div_q - CNT_W'(1));
   assign os_last  = (os_cnt_q == os_div - CNT_W'(1));
   assign load_ok  = div_load && (div_in >= CNT_W'(2));

   always_comb begin
      div_d        = div_q;
      pend_div_d   = pend_div_q;
      pend_v_d     = pend_v_q;
      cnt_d        = '0;
      os_cnt_d     = '0;
      bit_idx_d    = '0;
      tick_mid_d   = 1'b0;
      tick_end_d   = 1'b0;
      tick_os_d    = 1'b0;
      frame_done_d = 1'b0;
      div_err_d    = div_load && !load_ok;

      if (bps_start) begin
         cnt_d      = cnt_last ? '0 : cnt_q + CNT_W'(1);
         os_cnt_d   = os_last ? '0 : os_cnt_q + CNT_W'(1);
         bit_idx_d  = bit_idx_q;
         tick_mid_d = (cnt_q == half);
         tick_end_d = cnt_last;
         tick_os_d  = os_last;
         if (cnt_last) begin
            bit_idx_d    = (bit_idx_q == LAST_BIT) ? 4'd0 : bit_idx_q + 4'd1;
            frame_done_d = (bit_idx_q == LAST_BIT);
            // A pending divisor only takes effect on a bit boundary
            if (pend_v_q) begin
               div_d    = pend_div_q;
               pend_v_d = 1'b0;
               os_cnt_d = '0;
            end
         end
      end else if (pend_v_q) begin
         div_d    = pend_div_q;
         pend_v_d = 1'b0;
      end

      if (load_ok) begin
         if (bps_start) begin
            pend_div_d = div_in;
            pend_v_d   = 1'b1;
         end else begin
            div_d    = div_in;
            pend_v_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         div_q        <= DEF_DIV;
         pend_div_q   <= '0;
         pend_v_q     <= 1'b0;
         cnt_q        <= '0;
         os_cnt_q     <= '0;
         bit_idx_q    <= '0;
         tick_mid_q   <= 1'b0;
         tick_end_q   <= 1'b0;
         tick_os_q    <= 1'b0;
         frame_done_q <= 1'b0;
         div_err_q    <= 1'b0;
      end else begin
         div_q        <= div_d;
         pend_div_q   <= pend_div_d;
         pend_v_q     <= pend_v_d;
         cnt_q        <= cnt_d;
         os_cnt_q     <= os_cnt_d;
         bit_idx_q    <= bit_idx_d;
         tick_mid_q   <= tick_mid_d;
         tick_end_q   <= tick_end_d;
         tick_os_q    <= tick_os_d;
         frame_done_q <= frame_done_d;
         div_err_q    <= div_err_d;
      end
   end

   assign tick_mid   = tick_mid_q;
   assign tick_end   = tick_end_q;
   assign tick_os    = tick_os_q;
   assign bit_idx    = bit_idx_q;
   assign frame_done = frame_done_q;
   assign div_err    = div_err_q;
   assign div_cur    = div_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Testbench for baud_tick_gen: directed plan steps plus random traffic, each cycle
// compared against an edge-counting reference model of the bit timing.
module tb_baud_tick_gen;

   localparam int DEF = 5208;
   localparam int FB  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        bps_start = 1'b0;
   logic [15:0] div_in = '0;
   logic        div_load = 1'b0;
   logic        tick_mid, tick_end, tick_os, frame_done, div_err;
   logic [3:0]  bit_idx;
   logic [15:0] div_cur;

   baud_tick_gen #(.CNT_W(16), .DEFAULT_DIV(DEF), .OS_LOG2(4), .FRAME_BITS(FB)) dut (
      .clk(clk), .reset(reset), .bps_start(bps_start), .div_in(div_in),
      .div_load(div_load), .tick_mid(tick_mid), .tick_end(tick_end),
      .tick_os(tick_os), .bit_idx(bit_idx), .frame_done(frame_done),
      .div_err(div_err), .div_cur(div_cur)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: edges elapsed in the current bit and since the oversample restart
   int m_div = DEF, m_pend = 0, m_pv = 0, m_n = 0, m_os_n = 0, m_bit = 0;
   int e_mid, e_end, e_os, e_fd, e_err;

   int edge_no = 0;
   int first_mid = 0, first_end = 0, fd_edge = 0, os_count = 0, err_count = 0;
   int end_edges[$];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelEdge(input logic rst_n, input logic bps, input logic ld, input int din);
      int osd;
      e_mid = 0; e_end = 0; e_os = 0; e_fd = 0; e_err = 0;
      if (!rst_n) begin
         m_div = DEF; m_pv = 0; m_n = 0; m_os_n = 0; m_bit = 0;
         return;
      end
      e_err = (ld && din < 2) ? 1 : 0;
      if (bps) begin
         m_n++;
         m_os_n++;
         osd   = (m_div / 16 < 1) ? 1 : m_div / 16;
         e_mid = (m_n == m_div / 2 + 1) ? 1 : 0;
         e_end = (m_n == m_div) ? 1 : 0;
         e_os  = (m_os_n % osd == 0) ? 1 : 0;
         if (e_end) begin
            e_fd  = (m_bit == FB - 1) ? 1 : 0;
            m_bit = (m_bit + 1) % FB;
            m_n   = 0;
            if (m_pv) begin
               m_div = m_pend; m_pv = 0; m_os_n = 0;
            end
         end
      end else begin
         m_n = 0; m_os_n = 0; m_bit = 0;
         if (m_pv) begin
            m_div = m_pend; m_pv = 0;
         end
      end
      if (ld && din >= 2) begin
         if (bps) begin
            m_pend = din; m_pv = 1;
         end else begin
            m_div = din; m_pv = 0;
         end
      end
   endtask

   task automatic applyStimulus(input logic rst_n, input logic bps, input logic ld, input logic [15:0] din);
      reset = rst_n; bps_start = bps; div_load = ld; div_in = din;
      @(posedge clk);
      modelEdge(rst_n, bps, ld, int'(din));
      edge_no = (rst_n && bps) ? edge_no + 1 : 0;
      #1;
      checkOutput("tick_mid",   32'(tick_mid),   32'(e_mid));
      checkOutput("tick_end",   32'(tick_end),   32'(e_end));
      checkOutput("tick_os",    32'(tick_os),    32'(e_os));
      checkOutput("frame_done", 32'(frame_done), 32'(e_fd));
      checkOutput("div_err",    32'(div_err),    32'(e_err));
      checkOutput("bit_idx",    32'(bit_idx),    32'(m_bit));
      checkOutput("div_cur",    32'(div_cur),    32'(m_div));
      if (tick_mid === 1'b1 && first_mid == 0) first_mid = edge_no;
      if (tick_end === 1'b1) begin
         if (first_end == 0) first_end = edge_no;
         end_edges.push_back(edge_no);
      end
      if (frame_done === 1'b1 && fd_edge == 0) fd_edge = edge_no;
      if (tick_os === 1'b1) os_count++;
      if (div_err === 1'b1) err_count++;
   endtask

   task automatic clearMarks();
      first_mid = 0; first_end = 0; fd_edge = 0; os_count = 0; err_count = 0;
      end_edges.delete();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, 16'd0);
   endtask

   initial begin
      // Reset state
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);
      checkOutput("reset_div_cur", 32'(div_cur), 32'(DEF));

      // Default divisor, one full frame
      clearMarks();
      run(FB * DEF);
      checkOutput("def_first_mid", first_mid, 2605);
      checkOutput("def_first_end", first_end, 5208);
      checkOutput("def_frame_done_edge", fd_edge, FB * DEF);
      checkOutput("def_os_count", os_count, (FB * DEF) / 325);
      checkOutput("def_bit_idx_wrap", 32'(bit_idx), 0);

      // Idle load of 32 then start
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 16'd32);
      checkOutput("idle_load_div_cur", 32'(div_cur), 32);
      clearMarks();
      run(64);
      checkOutput("d32_first_mid", first_mid, 17);
      checkOutput("d32_first_end", first_end, 32);
      checkOutput("d32_os_count", os_count, 32);

      // Rejected loads
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0);
      clearMarks();
      applyStimulus(1'b1, 1'b0, 1'b1, 16'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 16'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0);
      checkOutput("bad_load_err_count", err_count, 2);
      checkOutput("bad_load_div_cur", 32'(div_cur), 32);

      // Mid-bit loads take effect only at bit boundaries
      clearMarks();
      run(9);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'd20);
      run(49);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'd20);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'd24);
      run(38);
      checkOutput("pend_end_count", end_edges.size(), 4);
      if (end_edges.size() >= 4) begin
         checkOutput("pend_end0", end_edges[0], 32);
         checkOutput("pend_end1", end_edges[1], 52);
         checkOutput("pend_end2", end_edges[2], 72);
         checkOutput("pend_end3", end_edges[3], 96);
      end
      checkOutput("pend_div_cur", 32'(div_cur), 24);

      // One-cycle bps_start drop mid-bit
      run(12);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0);
      checkOutput("drop_strobes", 32'({tick_mid, tick_end, tick_os, frame_done}), 0);
      checkOutput("drop_bit_idx", 32'(bit_idx), 0);
      clearMarks();
      run(30);
      checkOutput("drop_restart_mid", first_mid, 13);
      checkOutput("drop_restart_end", first_end, 24);

      // Reset discards a pending divisor
      applyStimulus(1'b1, 1'b1, 1'b1, 16'd40);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
      checkOutput("rst_pend_div_cur", 32'(div_cur), DEF);
      checkOutput("rst_pend_strobes", 32'({tick_mid, tick_end, tick_os, frame_done, div_err}), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0);
      run(50);
      checkOutput("rst_pend_never_applied", 32'(div_cur), DEF);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         logic        r_rst, r_bps, r_ld;
         logic [15:0] r_din;
         r_rst = ($urandom_range(0, 499) != 0);
         r_bps = ($urandom_range(0, 19) != 0);
         r_ld  = ($urandom_range(0, 29) == 0);
         r_din = 16'($urandom_range(0, 60));
         applyStimulus(r_rst, r_bps, r_ld, r_din);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
